// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit, request handshake to word-addressed memory port.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module riscv_lsu #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [1:0]        a;
  logic [1:0]        req_sz;
  logic [1:0]        req_lane;
  logic [3:0]        req_be;
  logic [31:0]       req_wd;
  logic              trap;
  logic [15:0]       sel;
  logic [31:0]       ext;

  // Decode the incoming request into lane, byte enables and replicated data.
  always_comb begin
    a        = req_addr[1:0];
    req_sz   = (req_size == 2'b11) ? 2'b10 : req_size;
    req_lane = 2'b00;
    req_be   = 4'b1111;
    req_wd   = req_wdata;
    unique case (req_sz)
      2'b00: begin
        req_lane = a;
        req_be   = 4'b0001 << a;
        req_wd   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_lane = {a[1], 1'b0};
        req_be   = 4'b0011 << {a[1], 1'b0};
        req_wd   = {2{req_wdata[15:0]}};
      end
      default: begin
        req_lane = 2'b00;
        req_be   = 4'b1111;
        req_wd   = req_wdata;
      end
    endcase
`ifdef MISALIGN_TRAP_EN
    trap = (req_size == 2'b11)
         | ((req_size == 2'b01) & a[0])
         | ((req_size == 2'b10) & (a != 2'b00));
`else
    trap = 1'b0;
`endif
  end

  // Select the addressed byte/half from the read word and extend it.
  always_comb begin
    sel = 16'(mem_rdata >> {lane_q, 3'b000});
    unique case (size_q)
      2'b00:   ext = uns_q ? {24'd0, sel[7:0]}
                           : {{24{sel[7]}}, sel[7:0]};
      2'b01:   ext = uns_q ? {16'd0, sel}
                           : {{16{sel[15]}}, sel};
      default: ext = mem_rdata;
    endcase
  end

  // Next-state and datapath update for IDLE -> ACCESS -> RESP.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_sz;
          uns_d   = req_unsigned;
          lane_d  = req_lane;
          be_d    = req_be;
          addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          wdata_d = req_wd;
          cnt_d   = '0;
          if (trap) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : ext;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers; reset drops the access at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_en     = (state_q == ACCESS);
  assign mem_we     = mem_en & we_q;
  assign mem_be     = be_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed bench for riscv_lsu with a transaction-level model.
// Works with or without MISALIGN_TRAP_EN defined.
module tb_riscv_lsu;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack;

  riscv_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endfunction

  // transaction model
  bit          active = 1'b0;
  bit          ack_force = 1'b1;
  int          t_acc, en_n, resp_cyc, ack_cyc;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_be;
  logic        e_we, e_err;
  int          en_count, resp_count;
  logic [31:0] last_rdata, last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_err;
  logic [31:0] mem_m [logic [31:0]];

  assign mem_ack = ack_force
                 | (active && ack_cyc >= 0 && cyc == ack_cyc);

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return 32'd0;
  endfunction

  // Per-cycle comparison of DUT outputs with the model timeline.
  always @(negedge clk) begin
    if (!active) begin
      check("idle_ready", {31'd0, req_ready}, 32'd1);
      check("idle_mem_en", {31'd0, mem_en}, 32'd0);
      check("idle_resp", {31'd0, resp_valid}, 32'd0);
    end else begin
      check("mem_en", {31'd0, mem_en},
            {31'd0, (cyc > t_acc && cyc <= t_acc + en_n)});
      check("resp_valid", {31'd0, resp_valid},
            {31'd0, (cyc == resp_cyc)});
      check("req_ready", {31'd0, req_ready},
            {31'd0, !(cyc > t_acc && cyc <= resp_cyc)});
      if (mem_en) begin
        en_count++;
        check("mem_addr", mem_addr, e_addr);
        check("mem_be", {28'd0, mem_be}, {28'd0, e_be});
        check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        check("mem_wdata", mem_wdata, e_wdata);
        last_addr  = mem_addr;
        last_be    = mem_be;
        last_wdata = mem_wdata;
      end
      if (resp_valid) begin
        resp_count++;
        check("resp_rdata", resp_rdata, e_rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e_err});
        last_rdata = resp_rdata;
        last_err   = resp_err;
      end
    end
  end

  task automatic setup(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input int k,
                       output bit acked);
    logic [1:0]  se, off;
    logic [31:0] w, v;
    bit          mis, trap;
    se  = (sz == 2'b11) ? 2'b10 : sz;
    mis = (sz == 2'b11) || (sz == 2'b01 && a[0])
       || (sz == 2'b10 && a[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    off = (se == 2'b00) ? a[1:0]
        : (se == 2'b01) ? {a[1], 1'b0} : 2'b00;
    e_addr  = {a[31:2], 2'b00};
    e_be    = (se == 2'b00) ? (4'b0001 << off)
            : (se == 2'b01) ? (4'b0011 << off) : 4'b1111;
    e_wdata = (se == 2'b00) ? {4{wd[7:0]}}
            : (se == 2'b01) ? {2{wd[15:0]}} : wd;
    e_we    = we;
    w       = rd(e_addr);
    mem_rdata = w;
    if (trap) en_n = 0;
    else if (k < 0 || k >= T) en_n = T;
    else en_n = k + 1;
    acked    = !trap && k >= 0 && k < T;
    t_acc    = cyc;
    resp_cyc = cyc + 1 + en_n;
    ack_cyc  = acked ? cyc + 1 + k : -1;
    e_err    = !acked;
    v        = w >> (8 * off);
    if (!acked || we) e_rdata = 32'd0;
    else if (se == 2'b00)
      e_rdata = uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    else if (se == 2'b01)
      e_rdata = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    else e_rdata = w;
    en_count   = 0;
    resp_count = 0;
    active     = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
  endtask

  // k = ack wait cycles; k < 0 means never acknowledge.
  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input int k);
    bit acked;
    logic [31:0] w;
    @(negedge clk); #1;
    setup(we, sz, uns, a, wd, k, acked);
    @(negedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 100 && cyc <= resp_cyc; i++) @(negedge clk);
    if (cyc <= resp_cyc) check("txn_bound", 32'd0, 32'd1);
    #1;
    active = 1'b0;
    if (acked && we) begin
      w = rd(e_addr);
      for (int b = 0; b < 4; b++)
        if (e_be[b]) w[8*b +: 8] = e_wdata[8*b +: 8];
      mem_m[e_addr] = w;
    end
    check("resp_count", resp_count, 32'd1);
  endtask

  initial begin
    bit acked;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    ack_force = 1'b0;

    // 1: sw / lw
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0);
    check("t1_be", {28'd0, last_be}, 32'hF);
    check("t1_en", en_count, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 0);
    check("t1_lw", last_rdata, 32'hDEADBEEF);
    check("t1_err", {31'd0, last_err}, 32'd0);

    // 2: sub-word loads
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h80FF1234, 1);
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 0);
    check("t2_lb", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 0);
    check("t2_lbu", last_rdata, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 0);
    check("t2_lh", last_rdata, 32'hFFFF80FF);
    do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 2);
    check("t2_lhu", last_rdata, 32'h000080FF);

    // 3: sh
    do_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 0);
    check("t3_addr", last_addr, 32'h200);
    check("t3_be", {28'd0, last_be}, 32'hC);
    check("t3_wdata", last_wdata, 32'hABCDABCD);

    // 4: delayed ack
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 3);
    check("t4_en", en_count, 32'd4);
    check("t4_rdata", last_rdata, 32'h80FF1234);

    // 5: timeout
    do_req(1'b0, 2'b10, 1'b0, 32'h300, 32'd0, -1);
    check("t5_en", en_count, 32'd8);
    check("t5_err", {31'd0, last_err}, 32'd1);
    check("t5_rdata", last_rdata, 32'd0);
    check("t5_ready", {31'd0, req_ready}, 32'd1);

    // byte store then load back
    do_req(1'b1, 2'b00, 1'b0, 32'h301, 32'h0000005A, 1);
    check("sb_be", {28'd0, last_be}, 32'h2);
    check("sb_wdata", last_wdata, 32'h5A5A5A5A);
    do_req(1'b0, 2'b00, 1'b1, 32'h301, 32'd0, 0);
    check("lbu_5a", last_rdata, 32'h5A);

    // 6: misaligned word load, reserved size
    do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 0);
`ifdef MISALIGN_TRAP_EN
    check("t6_err", {31'd0, last_err}, 32'd1);
    check("t6_en", en_count, 32'd0);
`else
    check("t6_addr", last_addr, 32'h100);
    check("t6_rdata", last_rdata, 32'h80FF1234);
`endif
    do_req(1'b1, 2'b11, 1'b0, 32'h500, 32'h11223344, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h500, 32'd0, 0);
`ifdef MISALIGN_TRAP_EN
    check("sz3_rd", last_rdata, 32'd0);
`else
    check("sz3_rd", last_rdata, 32'h11223344);
`endif

    // reset in the middle of an access
    @(negedge clk); #1;
    setup(1'b0, 2'b10, 1'b0, 32'h400, 32'd0, -1, acked);
    @(negedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    active = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_en", {31'd0, mem_en}, 32'd0);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (T + 3) @(negedge clk);
    #1;
    check("post_rst_resp", {31'd0, resp_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
